// File: rtl/tms34020_mem_pkg.sv
// Shared types and helpers for the TMS34020 byte-enable dual-port RAM.
// Holds the clear-sequencer state encoding and the per-byte merge used by
// both the array write path and the same-address forwarding path.
package tms34020_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Select the new byte when its enable is set, otherwise keep the old byte.
  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/tms34020_clr_seq.sv
// Clear sequencer: walks every address once, issuing an all-zero write per
// cycle. Starts after reset when INIT_CLR is set, or on a CLR pulse in IDLE.
import tms34020_mem_pkg::*;

module tms34020_clr_seq #(
  parameter int AW       = 7,
  parameter int INIT_CLR = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  output logic          busy_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          clr_we_o
);

  localparam clr_state_t    RST_STATE = (INIT_CLR != 0) ? CLEAR : IDLE;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  clr_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and address counter registers; reset aborts any running clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: CLR only matters in IDLE; CLEAR ends after the top address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/tms34020_dpram_be.sv
// Simple dual-port RAM with per-byte write enables, optional registered
// read port and a built-in zero-fill sequencer.
// Optional feature macro: TMS34020_DPRAM_FWD_EN (same-address read-during-write
// forwarding of the merged write data).
import tms34020_mem_pkg::*;

module tms34020_dpram_be #(
  parameter int DW       = 32,
  parameter int AW       = 7,
  parameter int OREG     = 0,
  parameter int INIT_CLR = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CLR,
  output logic            BUSY,
  input  logic [AW-1:0]   WADDR,
  input  logic [DW-1:0]   DATA,
  input  logic            WREN,
  input  logic [DW/8-1:0] BE,
  input  logic [AW-1:0]   RADDR,
  input  logic            RDEN,
  output logic [DW-1:0]   Q
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  logic          busy;
  logic [AW-1:0] clr_addr;
  logic          clr_we;

  tms34020_clr_seq #(
    .AW       (AW),
    .INIT_CLR (INIT_CLR)
  ) u_clr_seq (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .clr_i      (CLR),
    .busy_o     (busy),
    .clr_addr_o (clr_addr),
    .clr_we_o   (clr_we)
  );

  assign BUSY = busy;

  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] wr_old;
  logic [DW-1:0] wr_word;

  // Write-port mux: the sequencer owns the port while busy, user writes are dropped.
  always_comb begin
    wr_addr = WADDR;
    wr_data = DATA;
    wr_be   = '0;
    if (clr_we) begin
      wr_addr = clr_addr;
      wr_data = '0;
      wr_be   = '1;
    end else if (WREN) begin
      wr_be   = BE;
    end
  end

  assign wr_old = mem[wr_addr];

  for (genvar b = 0; b < NB; b++) begin : g_wr_merge
    assign wr_word[8*b +: 8] = be_merge(wr_old[8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
  end

  // Array write; untouched bytes are carried through by the merge.
  always_ff @(posedge CLK) begin
    if (|wr_be) begin
      mem[wr_addr] <= wr_word;
    end
  end

  logic [DW-1:0] rd_old;
  logic [DW-1:0] rd_word;

  assign rd_old = mem[RADDR];

`ifdef TMS34020_DPRAM_FWD_EN
  logic [DW-1:0] fwd_word;
  logic          fwd_hit;

  for (genvar b = 0; b < NB; b++) begin : g_fwd_merge
    assign fwd_word[8*b +: 8] = be_merge(rd_old[8*b +: 8], DATA[8*b +: 8], BE[b]);
  end

  assign fwd_hit = WREN && !busy && (WADDR == RADDR);
  assign rd_word = fwd_hit ? fwd_word : rd_old;
`else
  assign rd_word = rd_old;
`endif

  if (OREG != 0) begin : g_oreg
    logic [DW-1:0] q_q, q_d;

    // Output register load: zero while clearing, new data on RDEN, else hold.
    always_comb begin
      q_d = q_q;
      if (busy) begin
        q_d = '0;
      end else if (RDEN) begin
        q_d = rd_word;
      end
    end

    // Registered read data, reset to zero.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        q_q <= '0;
      end else begin
        q_q <= q_d;
      end
    end

    assign Q = busy ? '0 : q_q;
  end else begin : g_comb
    logic unused_rden;
    assign unused_rden = RDEN;
    assign Q = busy ? '0 : rd_word;
  end

endmodule

// File: tb/tb_tms34020_dpram_be.sv
// Directed bench for tms34020_dpram_be: three instances (AW=4 combinational,
// AW=4 registered, AW=2 combinational) sharing clock and reset.
module tb_tms34020_dpram_be;

`ifdef TMS34020_DPRAM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [3:0]  waddr, raddr;
  logic [31:0] data;
  logic        wren, rden;
  logic [3:0]  be;
  logic        busy_a, busy_b, busy_c;
  logic [31:0] q_a, q_b, q_c;
  logic        clr_c, wren_c;
  logic [1:0]  waddr_c, raddr_c;

  int n_cmp  = 0;
  int n_fail = 0;
  int n;

  always #5 clk = ~clk;

  tms34020_dpram_be #(.DW(32), .AW(4), .OREG(0), .INIT_CLR(1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .BUSY(busy_a), .WADDR(waddr), .DATA(data),
    .WREN(wren), .BE(be), .RADDR(raddr), .RDEN(rden), .Q(q_a));

  tms34020_dpram_be #(.DW(32), .AW(4), .OREG(1), .INIT_CLR(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .BUSY(busy_b), .WADDR(waddr), .DATA(data),
    .WREN(wren), .BE(be), .RADDR(raddr), .RDEN(rden), .Q(q_b));

  tms34020_dpram_be #(.DW(32), .AW(2), .OREG(0), .INIT_CLR(1)) dut_c (
    .CLK(clk), .RST_N(rst_n), .CLR(clr_c), .BUSY(busy_c), .WADDR(waddr_c), .DATA(data),
    .WREN(wren_c), .BE(be), .RADDR(raddr_c), .RDEN(rden), .Q(q_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; clr_c = 1'b0;
    waddr = '0; raddr = '0; data = '0; wren = 1'b0; rden = 1'b0; be = '0;
    wren_c = 1'b0; waddr_c = '0; raddr_c = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy_a", {31'b0, busy_a}, 32'd1);
    chk("rst_busy_c", {31'b0, busy_c}, 32'd1);
    chk("rst_q_a", q_a, 32'h0);
    chk("rst_q_b", q_b, 32'h0);

    // Power-on clear with user writes to address 3 held throughout
    rst_n = 1'b1;
    wren = 1'b1; waddr = 4'd3; data = 32'hFFFF_FFFF; be = 4'hF; raddr = 4'd3; rden = 1'b1;
    n = 0;
    while (busy_a && n < 200) begin
      chk("busy_q_a", q_a, 32'h0);
      chk("busy_q_b", q_b, 32'h0);
      @(negedge clk);
      n++;
    end
    wren = 1'b0;
    chk("poweron_busy_cycles", n, 32'd16);
    for (int i = 0; i < 16; i++) begin
      raddr = i[3:0]; rden = 1'b1;
      #1 chk("poweron_read_a", q_a, 32'h0);
      @(negedge clk);
      chk("poweron_read_b", q_b, 32'h0);
    end
    rden = 1'b0;

    // Byte-masked writes to address 5
    wren = 1'b1; waddr = 4'd5; data = 32'hAABB_CCDD; be = 4'hF;
    @(negedge clk);
    data = 32'h1122_3344; be = 4'b0101;
    @(negedge clk);
    wren = 1'b0; raddr = 4'd5; rden = 1'b1;
    #1 chk("bytemask_a", q_a, 32'hAA22_CC44);
    @(negedge clk);
    chk("bytemask_b", q_b, 32'hAA22_CC44);
    rden = 1'b0;

    // Read-during-write on the combinational port, byte 1 only
    wren = 1'b1; waddr = 4'd5; data = 32'h0000_0000; be = 4'b0010; raddr = 4'd5;
    #1 chk("rdw_comb_before_edge", q_a, FWD ? 32'hAA22_0044 : 32'hAA22_CC44);
    @(negedge clk);
    wren = 1'b0;
    #1 chk("rdw_comb_after_edge", q_a, 32'hAA22_0044);
    chk("oreg_hold_no_rden", q_b, 32'hAA22_CC44);
    rden = 1'b1;
    @(negedge clk);
    chk("oreg_read_updated", q_b, 32'hAA22_0044);

    // Registered port holds when RDEN is low
    rden = 1'b0; raddr = 4'd7;
    @(negedge clk);
    chk("oreg_hold_addr_change", q_b, 32'hAA22_0044);

    // Same-address read-during-write at address 7 (old value 0)
    wren = 1'b1; rden = 1'b1; waddr = 4'd7; raddr = 4'd7; data = 32'h1234_5678; be = 4'hF;
    #1 chk("fwd_comb", q_a, FWD ? 32'h1234_5678 : 32'h0);
    @(negedge clk);
    chk("fwd_oreg", q_b, FWD ? 32'h1234_5678 : 32'h0);
    wren = 1'b0;
    @(negedge clk);
    chk("addr7_after_write", q_b, 32'h1234_5678);
    rden = 1'b0;

    // Reset mid-clear: mark address 12 first, abort at CNT=9
    wren = 1'b1; waddr = 4'd12; data = 32'hDEAD_BEEF; be = 4'hF;
    @(negedge clk);
    wren = 1'b0; raddr = 4'd12;
    #1 chk("addr12_written", q_a, 32'hDEAD_BEEF);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy_rise", {31'b0, busy_a}, 32'd1);
    repeat (9) @(negedge clk);
    chk("midclear_busy", {31'b0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_mid_busy", {31'b0, busy_a}, 32'd1);
    chk("rst_mid_q_b", q_b, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy_a && n < 200) begin
      clr = (n == 5);
      @(negedge clk);
      n++;
    end
    clr = 1'b0;
    chk("restart_busy_cycles", n, 32'd16);
    for (int i = 0; i < 16; i++) begin
      raddr = i[3:0]; rden = 1'b1;
      #1 chk("restart_read_a", q_a, 32'h0);
      @(negedge clk);
      chk("restart_read_b", q_b, 32'h0);
    end
    rden = 1'b0;

    // Small array: wrap and re-clear
    chk("c_idle", {31'b0, busy_c}, 32'd0);
    wren_c = 1'b1; waddr_c = 2'd3; data = 32'h0000_0055; be = 4'hF;
    @(negedge clk);
    waddr_c = 2'd0; data = 32'h0000_0077;
    @(negedge clk);
    wren_c = 1'b0; raddr_c = 2'd3;
    #1 chk("c_addr3_written", q_c, 32'h0000_0055);
    raddr_c = 2'd0;
    #1 chk("c_addr0_written", q_c, 32'h0000_0077);
    for (int k = 0; k < 2; k++) begin
      clr_c = 1'b1;
      @(negedge clk);
      clr_c = 1'b0;
      chk("c_busy_rise", {31'b0, busy_c}, 32'd1);
      n = 0;
      while (busy_c && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("c_busy_cycles", n, 32'd4);
      for (int i = 0; i < 4; i++) begin
        raddr_c = i[1:0];
        #1 chk("c_read_cleared", q_c, 32'h0);
      end
      if (k == 0) begin
        wren_c = 1'b1; waddr_c = 2'd0; data = 32'h0000_0099;
        @(negedge clk);
        wren_c = 1'b0; raddr_c = 2'd0;
        #1 chk("c_rewrite", q_c, 32'h0000_0099);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
